pong_matrix_scanner: RTL and testbench

- Parametrised successor to the per-row pong renderer, for a WIDTH x HEIGHT LED matrix.
- Owns its own row scan: prescaler, row counter and frame counter.
- Takes a frame-coherent snapshot of ball/paddle positions at each frame start, so a frame never tears.
- Drives registered one-hot row select plus column data. Adds optional ball blink and a scan enable. Sits between game logic and the matrix driver pins.

---
 rtl/pong_matrix_scanner.sv | 140 ++++++++++++++
 tb/tb_pong_matrix_scanner.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pong_matrix_scanner.sv
// pong_matrix_scanner
//   Row-scanned renderer for a WIDTH x HEIGHT pong LED matrix. It runs its own
//   scan: a prescaler holds each row for SCAN_DIV clocks, a row counter walks
//   rows 0..HEIGHT-1, and a frame counter drives the optional ball blink.
//   Ball and paddle positions are captured once per frame, at the frame-start
//   state, so a frame never mixes old and new positions.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset
//   en           scan enable; low holds the scan position and blanks the outputs
//   blink_en     1 = ball blinks with period BLINK_FRAMES frames
//   x_pos/y_pos  ball column / row
//   player_top   top paddle left column (row 0)
//   player_down  bottom paddle left column (row HEIGHT-1)
//   row_sel      registered one-hot active row
//   col_out      registered lit columns of the active row (bit i = column i)
//   frame_start  one-clock pulse on the first output cycle of row 0

module pong_matrix_scanner #(
    parameter int WIDTH        = 8,
    parameter int HEIGHT       = 8,
    parameter int X_BITS       = 3,
    parameter int Y_BITS       = 3,
    parameter int PADDLE_SIZE  = 2,
    parameter int SCAN_DIV     = 4,
    parameter int BLINK_FRAMES = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              blink_en,
    input  logic [X_BITS-1:0] x_pos,
    input  logic [Y_BITS-1:0] y_pos,
    input  logic [X_BITS-1:0] player_top,
    input  logic [X_BITS-1:0] player_down,
    output logic [HEIGHT-1:0] row_sel,
    output logic [WIDTH-1:0]  col_out,
    output logic              frame_start
);

    localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FC_W  = $clog2(BLINK_FRAMES);

    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [Y_BITS-1:0] ROW_LAST = Y_BITS'(HEIGHT - 1);
    localparam logic [FC_W-1:0]   FC_LAST  = FC_W'(BLINK_FRAMES - 1);
    localparam logic [FC_W-1:0]   FC_HALF  = FC_W'(BLINK_FRAMES / 2);

    logic [PRE_W-1:0]  pre;
    logic [Y_BITS-1:0] row;
    logic [FC_W-1:0]   frame_cnt;

    logic [X_BITS-1:0] snap_x;
    logic [Y_BITS-1:0] snap_y;
    logic [X_BITS-1:0] snap_top;
    logic [X_BITS-1:0] snap_down;

    logic              load;
    logic              ball_vis;
    logic [X_BITS-1:0] eff_x;
    logic [Y_BITS-1:0] eff_y;
    logic [X_BITS-1:0] eff_top;
    logic [X_BITS-1:0] eff_down;
    logic [WIDTH-1:0]  col_next;

    // The frame-start cycle renders straight from the live inputs, so row 0
    // of a new frame already reflects the snapshot being captured.
    assign load     = (pre == '0) && (row == '0);
    assign eff_x    = load ? x_pos       : snap_x;
    assign eff_y    = load ? y_pos       : snap_y;
    assign eff_top  = load ? player_top  : snap_top;
    assign eff_down = load ? player_down : snap_down;
    assign ball_vis = !blink_en || (frame_cnt < FC_HALF);

    // Paddle bounds are evaluated in int so p + PADDLE_SIZE - 1 cannot wrap.
    // The ball compare uses full-width positions, so x >= WIDTH or
    // y >= HEIGHT simply never matches a column/row instead of aliasing.
    always_comb begin
        col_next = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if ((i >= 1) && (i <= WIDTH - 2)) begin
                if ((row == '0) && (i >= int'(eff_top)) &&
                    (i <= int'(eff_top) + PADDLE_SIZE - 1))
                    col_next[i] = 1'b1;
                if ((row == ROW_LAST) && (i >= int'(eff_down)) &&
                    (i <= int'(eff_down) + PADDLE_SIZE - 1))
                    col_next[i] = 1'b1;
            end
            if (ball_vis && (eff_y == row) && (int'(eff_x) == i))
                col_next[i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre         <= '0;
            row         <= '0;
            frame_cnt   <= '0;
            snap_x      <= '0;
            snap_y      <= '0;
            snap_top    <= '0;
            snap_down   <= '0;
            row_sel     <= '0;
            col_out     <= '0;
            frame_start <= 1'b0;
        end else if (en) begin
            if (load) begin
                snap_x      <= x_pos;
                snap_y      <= y_pos;
                snap_top    <= player_top;
                snap_down   <= player_down;
                frame_start <= 1'b1;
            end else begin
                frame_start <= 1'b0;
            end

            row_sel <= HEIGHT'(1) << row;
            col_out <= col_next;

            if (pre == PRE_LAST) begin
                pre <= '0;
                if (row == ROW_LAST) begin
                    row       <= '0;
                    frame_cnt <= (frame_cnt == FC_LAST) ? '0 : frame_cnt + 1'b1;
                end else begin
                    row <= row + 1'b1;
                end
            end else begin
                pre <= pre + 1'b1;
            end
        end else begin
            // Scan position and snapshot hold; only the outputs blank.
            row_sel     <= '0;
            col_out     <= '0;
            frame_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pong_matrix_scanner.sv
// tb_pong_matrix_scanner
//   Scoreboard bench. The driver applies one input vector per clock and pushes
//   the response a reference model predicts for that clock; a monitor pops and
//   compares each registered output. The model tracks only the number of
//   enabled cycles since reset and derives row, frame and load from it.

module tb_pong_matrix_scanner;

    localparam int W     = 8;
    localparam int H     = 8;
    localparam int XB    = 4;
    localparam int YB    = 3;
    localparam int PS    = 2;
    localparam int DIV   = 4;
    localparam int BLINK = 4;
    localparam int FRAME = H * DIV;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          en = 1'b0;
    logic          blink_en = 1'b0;
    logic [XB-1:0] x_pos = '0;
    logic [YB-1:0] y_pos = '0;
    logic [XB-1:0] player_top = '0;
    logic [XB-1:0] player_down = '0;
    logic [H-1:0]  row_sel;
    logic [W-1:0]  col_out;
    logic          frame_start;

    pong_matrix_scanner #(
        .WIDTH(W), .HEIGHT(H), .X_BITS(XB), .Y_BITS(YB),
        .PADDLE_SIZE(PS), .SCAN_DIV(DIV), .BLINK_FRAMES(BLINK)
    ) dut (
        .clk(clk), .reset(reset), .en(en), .blink_en(blink_en),
        .x_pos(x_pos), .y_pos(y_pos),
        .player_top(player_top), .player_down(player_down),
        .row_sel(row_sel), .col_out(col_out), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [H-1:0] rs;
        logic [W-1:0] col;
        logic         fs;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    int m_pos = 0;
    int m_x = 0, m_y = 0, m_t = 0, m_d = 0;

    function automatic logic [W-1:0] paint_paddle(input int p);
        logic [W-1:0] c;
        int lo, hi;
        c  = '0;
        lo = (p < 1) ? 1 : p;
        hi = (p + PS - 1 > W - 2) ? W - 2 : p + PS - 1;
        for (int i = lo; i <= hi; i++) c[i] = 1'b1;
        return c;
    endfunction

    function automatic logic [W-1:0] model_cols(input int r, input bit vis);
        logic [W-1:0] c;
        c = '0;
        if (r == 0)     c = c | paint_paddle(m_t);
        if (r == H - 1) c = c | paint_paddle(m_d);
        if (vis && m_y == r && m_x < W) c[m_x] = 1'b1;
        return c;
    endfunction

    task automatic cyc(input bit r, input bit e, input bit b,
                       input int x, input int y, input int t, input int d);
        exp_t ex;
        int   phase, row, frame;
        bit   vis;
        @(posedge clk);
        #2;
        reset       = r;
        en          = e;
        blink_en    = b;
        x_pos       = XB'(x);
        y_pos       = YB'(y);
        player_top  = XB'(t);
        player_down = XB'(d);
        ex.rs = '0; ex.col = '0; ex.fs = 1'b0;
        if (r) begin
            m_pos = 0;
        end else if (e) begin
            phase = m_pos % FRAME;
            if (phase == 0) begin
                m_x = x; m_y = y; m_t = t; m_d = d;
                ex.fs = 1'b1;
            end
            row   = phase / DIV;
            frame = (m_pos / FRAME) % BLINK;
            vis   = !b || (frame < BLINK / 2);
            ex.rs  = H'(1) << row;
            ex.col = model_cols(row, vis);
            m_pos++;
        end
        exp_q.push_back(ex);
    endtask

    initial begin : monitor
        exp_t ex;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                ex = exp_q.pop_front();
                total++;
                if (row_sel !== ex.rs || col_out !== ex.col || frame_start !== ex.fs) begin
                    bad++;
                    $display("FAIL out t=%0t: row_sel=%b col_out=%b fs=%b, required row_sel=%b col_out=%b fs=%b",
                             $time, row_sel, col_out, frame_start, ex.rs, ex.col, ex.fs);
                end
            end
        end
    end

    initial begin : driver
        int x, y, t, d;
        bit b, e, r;

        // reset held with en=1, then idle
        repeat (3) cyc(1, 1, 0, 3, 4, 2, 5);
        repeat (6) cyc(0, 0, 0, 3, 4, 2, 5);

        // basic frames with defaults-style positions
        cyc(1, 1, 0, 3, 4, 2, 5);
        repeat (2 * FRAME + 5) cyc(0, 1, 0, 3, 4, 2, 5);

        // edges: paddles against the borders, ball in the corner
        while (m_pos % FRAME != 0) cyc(0, 1, 0, 3, 4, 2, 5);
        repeat (FRAME) cyc(0, 1, 0, 0, 0, 0, 6);
        // ball off-grid column, paddles fully off-grid
        repeat (FRAME) cyc(0, 1, 0, 9, 0, 12, 15);
        repeat (FRAME) cyc(0, 1, 0, 7, 7, 7, 8);

        // snapshot coherency: y changes while row 3 is shown
        while (m_pos % FRAME != 0) cyc(0, 1, 0, 3, 4, 2, 5);
        repeat (3 * DIV + 1) cyc(0, 1, 0, 3, 4, 2, 5);
        repeat (2 * FRAME) cyc(0, 1, 0, 3, 2, 2, 5);

        // blink over several frames, restarted from reset so frame 0 is known
        cyc(1, 1, 1, 3, 2, 2, 5);
        repeat (5 * FRAME + 3) cyc(0, 1, 1, 3, 2, 2, 5);

        // enable gap during row 5, pre 2
        while (m_pos % FRAME != 5 * DIV + 2) cyc(0, 1, 0, 4, 5, 1, 3);
        repeat (10) cyc(0, 0, 0, 6, 1, 4, 4);
        repeat (12) cyc(0, 1, 0, 6, 1, 4, 4);
        // reset pulse during row 6
        while (m_pos % FRAME != 6 * DIV + 1) cyc(0, 1, 0, 6, 1, 4, 4);
        cyc(1, 1, 0, 6, 1, 4, 4);
        repeat (FRAME + 4) cyc(0, 1, 0, 2, 6, 3, 0);

        // random traffic
        x = 0; y = 0; t = 0; d = 0; b = 0;
        for (int k = 0; k < 2500; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                x = $urandom_range(0, 15);
                y = $urandom_range(0, 7);
                t = $urandom_range(0, 15);
                d = $urandom_range(0, 15);
            end
            if ($urandom_range(0, 99) == 0) b = ~b;
            r = ($urandom_range(0, 299) == 0);
            e = ($urandom_range(0, 9) != 0);
            cyc(r, e, b, x, y, t, d);
        end

        repeat (2) @(posedge clk);
        #3;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expected outputs left unchecked, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
